// File: rtl/latch_bank_seq_pkg.sv
// Shared types for the latch bank sequencer: request opcodes, FSM state encoding
// and the phase counter width helper.
package latch_bank_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_CLR_ROW = 2'b01,
        OP_SET_ROW = 2'b10,
        OP_CLR_ALL = 2'b11
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_GATE    = 3'd2;
    localparam state_t ST_HOLD    = 3'd3;
    localparam state_t ST_RSPULSE = 3'd4;
    localparam state_t ST_FIN     = 3'd5;

    // Wide enough to hold the longest phase length; never narrower than one bit.
    function automatic int phase_cnt_w(input int s, input int g, input int h);
        int m;
        m = s;
        if (g > m) m = g;
        if (h > m) m = h;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/latch_bank_shadow.sv
// Shadow copy of the latch bank contents, updated when an operation finishes,
// with a combinational readback mux (out-of-range rows read as zero).
module latch_bank_shadow
    import latch_bank_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ROWS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_en,
    input  op_e                     upd_op,
    input  logic [$clog2(ROWS)-1:0] upd_row,
    input  logic [WIDTH-1:0]        upd_data,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [WIDTH-1:0]        rd_data
);

    localparam int ROW_W = $clog2(ROWS);

    logic [WIDTH-1:0] mem_q [ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (upd_en && (upd_op == OP_CLR_ALL || upd_row == ROW_W'(i))) begin
                    case (upd_op)
                        OP_WRITE:   mem_q[i] <= upd_data;
                        OP_SET_ROW: mem_q[i] <= '1;
                        default:    mem_q[i] <= '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rd_row == ROW_W'(i)) rd_data = mem_q[i];
        end
    end

endmodule

// File: rtl/latch_bank_seq.sv
// Sequencer driving a shared bank of level latches with setup/gate/hold spacing.
// Optional shadow readback store enabled by LATCH_BANK_SEQ_SHADOW_EN.
//
// state   | meaning
// IDLE    | ready for a request
// SETUP   | data on bus, gate low
// GATE    | data on bus, one row gate high
// HOLD    | data held after gate falls
// RSPULSE | row set/reset (or all resets) high
// FIN     | DONE/ERR pulse, one dead cycle before IDLE
module latch_bank_seq
    import latch_bank_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ROWS      = 8,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [$clog2(ROWS)-1:0] req_row,
    input  logic [WIDTH-1:0]        req_data,
    output logic                    done,
    output logic                    err,
    output logic                    busy,
    output logic [WIDTH-1:0]        lat_d,
    output logic [ROWS-1:0]         lat_g,
    output logic [ROWS-1:0]         lat_s,
    output logic [ROWS-1:0]         lat_r,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [WIDTH-1:0]        rd_data
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = phase_cnt_w(SETUP_CYC, GATE_CYC, HOLD_CYC);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'((GATE_CYC > 0) ? GATE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_ld;
    op_e                op_q;
    logic [ROW_W-1:0]   row_q;
    logic [WIDTH-1:0]   data_q;
    logic               err_q;

    logic               accept, tc, row_bad_in;
    op_e                eff_op;
    logic [ROW_W-1:0]   eff_row;
    logic [WIDTH-1:0]   eff_data;
    logic               eff_err;
    logic [ROWS-1:0]    row_hot;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign tc         = (cnt_q == '0);
    assign row_bad_in = (op_e'(req_op) != OP_CLR_ALL) && ({1'b0, req_row} >= (ROW_W + 1)'(ROWS));

    // In IDLE the next state is decided from the live request, afterwards from the captured copy.
    assign eff_op   = (state_q == ST_IDLE) ? op_e'(req_op) : op_q;
    assign eff_row  = (state_q == ST_IDLE) ? req_row       : row_q;
    assign eff_data = (state_q == ST_IDLE) ? req_data      : data_q;
    assign eff_err  = (state_q == ST_IDLE) ? row_bad_in    : err_q;
    assign row_hot  = ROWS'(1) << eff_row;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (row_bad_in)
                        state_d = ST_FIN;
                    else if (op_e'(req_op) == OP_WRITE)
                        state_d = (SETUP_CYC > 0) ? ST_SETUP : ST_GATE;
                    else
                        state_d = ST_RSPULSE;
                end
            end
            ST_SETUP:   if (tc) state_d = ST_GATE;
            ST_GATE:    if (tc) state_d = (HOLD_CYC > 0) ? ST_HOLD : ST_FIN;
            ST_HOLD:    if (tc) state_d = ST_FIN;
            ST_RSPULSE: if (tc) state_d = ST_FIN;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_ld = '0;
        case (state_d)
            ST_SETUP:   cnt_ld = SETUP_LD;
            ST_GATE:    cnt_ld = GATE_LD;
            ST_HOLD:    cnt_ld = HOLD_LD;
            ST_RSPULSE: cnt_ld = GATE_LD;
            default:    cnt_ld = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= cnt_ld;
            else if (!tc)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_WRITE;
            row_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= op_e'(req_op);
            row_q  <= req_row;
            data_q <= req_data;
            err_q  <= row_bad_in;
        end
    end

    // Outputs are decoded from the next state and registered, so the latch
    // controls come straight off flops and switch only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_d <= '0;
            lat_g <= '0;
            lat_s <= '0;
            lat_r <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            lat_d <= (state_d inside {ST_SETUP, ST_GATE, ST_HOLD}) ? eff_data : '0;
            lat_g <= (state_d == ST_GATE) ? row_hot : '0;
            lat_s <= (state_d == ST_RSPULSE && eff_op == OP_SET_ROW) ? row_hot : '0;
            if (state_d == ST_RSPULSE && eff_op == OP_CLR_ALL)
                lat_r <= '1;
            else if (state_d == ST_RSPULSE && eff_op == OP_CLR_ROW)
                lat_r <= row_hot;
            else
                lat_r <= '0;
            done  <= (state_d == ST_FIN);
            err   <= (state_d == ST_FIN) && eff_err;
            busy  <= (state_d != ST_IDLE);
        end
    end

`ifdef LATCH_BANK_SEQ_SHADOW_EN
    logic shadow_upd;
    assign shadow_upd = (state_q == ST_FIN) && !err_q;

    latch_bank_shadow #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_en   (shadow_upd),
        .upd_op   (op_q),
        .upd_row  (row_q),
        .upd_data (data_q),
        .rd_row   (rd_row),
        .rd_data  (rd_data)
    );
`else
    logic unused_rd_row;
    assign unused_rd_row = ^rd_row;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_latch_bank_seq.sv
// Bench for latch_bank_seq: two instances (8 rows and 6 rows) driven with directed
// and random requests, compared cycle by cycle against a timeline model.
module tb_latch_bank_seq;

    localparam int S = 1;
    localparam int G = 2;
    localparam int H = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid_v [2];
    logic [1:0]  op_v    [2];
    logic [2:0]  row_v   [2];
    logic [31:0] data_v  [2];
    logic [2:0]  rdrow_v [2];

    logic        ready_v [2];
    logic        done_v  [2];
    logic        err_v   [2];
    logic        busy_v  [2];
    logic [31:0] d_v     [2];
    logic [31:0] rd_v    [2];
    logic [7:0]  g_v     [2];
    logic [7:0]  s_v     [2];
    logic [7:0]  r_v     [2];
    logic [7:0]  g8, s8, r8;
    logic [5:0]  g6, s6, r6;

    logic [31:0] shadow_m [2][8];
    int checks = 0;
    int errors = 0;

    latch_bank_seq #(.WIDTH(32), .ROWS(8), .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_v[0]), .req_ready(ready_v[0]),
        .req_op(op_v[0]), .req_row(row_v[0]), .req_data(data_v[0]),
        .done(done_v[0]), .err(err_v[0]), .busy(busy_v[0]), .lat_d(d_v[0]),
        .lat_g(g8), .lat_s(s8), .lat_r(r8), .rd_row(rdrow_v[0]), .rd_data(rd_v[0])
    );

    latch_bank_seq #(.WIDTH(32), .ROWS(6), .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_v[1]), .req_ready(ready_v[1]),
        .req_op(op_v[1]), .req_row(row_v[1]), .req_data(data_v[1]),
        .done(done_v[1]), .err(err_v[1]), .busy(busy_v[1]), .lat_d(d_v[1]),
        .lat_g(g6), .lat_s(s6), .lat_r(r6), .rd_row(rdrow_v[1]), .rd_data(rd_v[1])
    );

    assign g_v[0] = g8;
    assign s_v[0] = s8;
    assign r_v[0] = r8;
    assign g_v[1] = {2'b00, g6};
    assign s_v[1] = {2'b00, s6};
    assign r_v[1] = {2'b00, r6};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rows_of(input int u);
        return (u == 0) ? 8 : 6;
    endfunction

    function automatic logic [31:0] exp_rd(input int u, input logic [2:0] r);
`ifdef LATCH_BANK_SEQ_SHADOW_EN
        return (int'(r) < rows_of(u)) ? shadow_m[u][r] : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_rd(input int u, input logic [2:0] r);
        rdrow_v[u] = r;
        #1;
        chk("rd_data", 64'(rd_v[u]), 64'(exp_rd(u, r)));
    endtask

    task automatic check_idle(input int u);
        chk("idle_ready", 64'(ready_v[u]), 64'd1);
        chk("idle_busy",  64'(busy_v[u]),  64'd0);
        chk("idle_done",  64'(done_v[u]),  64'd0);
        chk("idle_ctrl",  64'(g_v[u] | s_v[u] | r_v[u]), 64'd0);
        chk("idle_lat_d", 64'(d_v[u]), 64'd0);
    endtask

    // Called on a negedge with the addressed instance idle.
    task automatic run_op(input int u, input logic [1:0] op, input logic [2:0] row,
                          input logic [31:0] data, input bit hold);
        int n;
        bit bad;
        int len;
        logic [7:0] hot, allmask, eg, es, er;
        logic [31:0] ed;
        n       = rows_of(u);
        bad     = (op != 2'b11) && (int'(row) >= n);
        len     = bad ? 1 : ((op == 2'b00) ? S + G + H + 1 : G + 1);
        hot     = 8'd1 << row;
        allmask = (n == 8) ? 8'hFF : 8'h3F;

        chk("ready_pre", 64'(ready_v[u]), 64'd1);
        valid_v[u] = 1'b1;
        op_v[u]    = op;
        row_v[u]   = row;
        data_v[u]  = data;
        @(posedge clk);
        @(negedge clk);
        if (!hold) valid_v[u] = 1'b0;
        for (int k = 1; k <= len; k++) begin
            ed = (!bad && op == 2'b00 && k <= S + G + H) ? data : 32'd0;
            eg = (!bad && op == 2'b00 && k > S && k <= S + G) ? hot : 8'd0;
            es = (!bad && op == 2'b10 && k <= G) ? hot : 8'd0;
            if (!bad && op == 2'b01 && k <= G)      er = hot;
            else if (!bad && op == 2'b11 && k <= G) er = allmask;
            else                                    er = 8'd0;
            chk("lat_d", 64'(d_v[u]), 64'(ed));
            chk("lat_g", 64'(g_v[u]), 64'(eg));
            chk("lat_s", 64'(s_v[u]), 64'(es));
            chk("lat_r", 64'(r_v[u]), 64'(er));
            chk("done",  64'(done_v[u]), 64'(k == len));
            chk("err",   64'(err_v[u]),  64'(k == len && bad));
            chk("busy",  64'(busy_v[u]), 64'd1);
            chk("ready_busy", 64'(ready_v[u]), 64'd0);
            chk("g_onehot0",  64'($onehot0(g_v[u])), 64'd1);
            chk("g_vs_sr",    64'(g_v[u] & (s_v[u] | r_v[u])), 64'd0);
            if (k < len) @(negedge clk);
        end
        @(negedge clk);
        chk("post_ready", 64'(ready_v[u]), 64'd1);
        chk("post_busy",  64'(busy_v[u]),  64'd0);
        chk("post_done",  64'(done_v[u]),  64'd0);
        if (!bad) begin
            case (op)
                2'b00: shadow_m[u][row] = data;
                2'b01: shadow_m[u][row] = 32'd0;
                2'b10: shadow_m[u][row] = 32'hFFFF_FFFF;
                default: for (int i = 0; i < 8; i++) shadow_m[u][i] = 32'd0;
            endcase
        end
        check_rd(u, row);
        check_rd(u, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        logic [31:0] dr;
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dr;
        for (int u = 0; u < 2; u++) begin
            valid_v[u] = 1'b0; op_v[u] = 2'b00; row_v[u] = 3'd0;
            data_v[u] = 32'd0; rdrow_v[u] = 3'd0;
            for (int i = 0; i < 8; i++) shadow_m[u][i] = 32'd0;
        end

        #12;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ctrl", 64'(g_v[u] | s_v[u] | r_v[u]), 64'd0);
            chk("rst_lat_d", 64'(d_v[u]), 64'd0);
            chk("rst_flags", 64'({done_v[u], err_v[u], busy_v[u]}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0);
        check_idle(1);

        run_op(0, 2'b00, 3'd3, 32'hA5A5_0F0F, 1'b0);
        run_op(0, 2'b10, 3'd7, 32'h0, 1'b0);
        run_op(0, 2'b01, 3'd7, 32'h0, 1'b0);

        run_op(1, 2'b00, 3'd6, 32'hDEAD_BEEF, 1'b0);
        run_op(1, 2'b01, 3'd7, 32'h0, 1'b0);
        run_op(1, 2'b10, 3'd5, 32'h0, 1'b0);
        run_op(1, 2'b11, 3'd6, 32'h0, 1'b0);
        check_rd(1, 3'd7);

        // Reset in the first gate cycle of a write.
        dr = $urandom;
        valid_v[0] = 1'b1; op_v[0] = 2'b00; row_v[0] = 3'd5; data_v[0] = dr;
        @(posedge clk);
        #1 valid_v[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_gate_g", 64'(g_v[0]), 64'h20);
        chk("mid_gate_d", 64'(d_v[0]), 64'(dr));
        rst_n = 1'b0;
        #1;
        chk("rst_async_g", 64'(g_v[0]), 64'd0);
        chk("rst_async_d", 64'(d_v[0]), 64'd0);
        chk("rst_async_busy", 64'(busy_v[0]), 64'd0);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 8; i++) shadow_m[u][i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0);
        check_rd(0, 3'd5);
        run_op(0, 2'b00, 3'd5, 32'h0BAD_F00D, 1'b0);

        // Valid held high across three writes: each accepted only once idle.
        run_op(0, 2'b00, 3'd1, 32'h1111_0001, 1'b1);
        run_op(0, 2'b00, 3'd4, 32'h2222_0002, 1'b1);
        run_op(0, 2'b00, 3'd6, 32'h3333_0003, 1'b0);

        run_op(0, 2'b00, 3'd2, 32'h1234_5678, 1'b0);
        check_rd(0, 3'd2);
        run_op(0, 2'b11, 3'd0, 32'h0, 1'b0);
        check_rd(0, 3'd2);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
